clip_sequencer: RTL and testbench
=================================

// Module: clip_sequencer
// PURPOSE
//  Parametrised record/playback sequencer for N audio clips in one shared sample RAM.
//  Sits between the input synchronizers, the PDM deserializer (record source),
//  the PWM serializer (playback sink) and a single-port block RAM split into N clip regions.
//  Adds over the 2-bank controller: N clips, per-clip recorded-length tracking,
//  early stop and a loop-playback mode.
// PARAMETERS
//  NUM_CLIPS  4   number of clip regions; power of 2, >=2
//  ADDR_W     15  per-clip sample address width; clip depth = 2**ADDR_W samples
//  DATA_W     16  sample width
//  CLIP_W     $clog2(NUM_CLIPS)  derived; not overridden
// PORTS
//  clock_i        in   1               100 MHz clock
//  reset_i        in   1               reset: synchronous, active-high
//  play_i         in   1               play command pulse, already synchronized
//  record_i       in   1               record command pulse, already synchronized
//  stop_i         in   1               stop command pulse, already synchronized
//  loop_i         in   1               level; 1 = wrap playback at end of clip
//  play_clip_i    in   CLIP_W          clip to play; sampled on an accepted play_i
//  record_clip_i  in   CLIP_W          clip to record; sampled on an accepted record_i
//  rec_valid_i    in   1               deserializer sample strobe, one cycle
//  rec_data_i     in   DATA_W          deserializer sample; valid with rec_valid_i
//  sample_tick_i  in   1               playback sample-rate strobe, one cycle
//  play_valid_o   out  1               one-cycle strobe; play_data_o is new
//  play_data_o    out  DATA_W          sample to serializer; held between strobes
//  mem_en_o       out  1               RAM enable
//  mem_we_o       out  1               RAM write enable
//  mem_addr_o     out  CLIP_W+ADDR_W   {clip, sample index}
//  mem_wdata_o    out  DATA_W          RAM write data
//  mem_rdata_i    in   DATA_W          RAM read data; 1-cycle read latency
//  state_o        out  2               current state, for the LED driver
//  active_clip_o  out  CLIP_W          clip in use; 0 in IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; pointers 0; every clip length 0.
//  Reset mid-operation aborts at once; partial recording is discarded (length 0).
//  States: IDLE, RECORD, PLAY_REQ, PLAY_DATA.
//  IDLE:
//   - record_i -> RECORD with clip := record_clip_i, wr_ptr := 0.
//   - play_i with len[play_clip_i] != 0 -> PLAY_REQ with clip := play_clip_i, rd_ptr := 0.
//   - play_i with len == 0 is ignored; stays IDLE.
//   - record_i and play_i in the same cycle: record wins.
//  RECORD:
//   - On rec_valid_i, combinationally drive mem_en_o=1, mem_we_o=1, addr {clip,wr_ptr},
//     mem_wdata_o=rec_data_i; wr_ptr++ next cycle.
//   - Ends on stop_i, or after the write at wr_ptr = 2**ADDR_W-1 (full).
//     Then len[clip] := samples written (ADDR_W+1 bits; full = 2**ADDR_W) and state -> IDLE.
//   - stop_i and rec_valid_i in the same cycle: the sample is written, then stop.
//  PLAY_REQ:
//   - On sample_tick_i, drive mem_en_o=1, we=0, addr {clip,rd_ptr}; -> PLAY_DATA.
//   - stop_i -> IDLE; no read is issued.
//  PLAY_DATA (one cycle):
//   - play_data_o := mem_rdata_i; play_valid_o=1 next cycle (2 cycles after the tick).
//   - If rd_ptr+1 == len: with loop_i=1, rd_ptr := 0 and -> PLAY_REQ; else -> IDLE.
//   - Otherwise rd_ptr++ and -> PLAY_REQ.
//   - stop_i here: the pending sample is still output, then -> IDLE.
//  While not IDLE, play_i and record_i are ignored; only stop_i acts.
//  sample_tick_i during PLAY_DATA is dropped; the sample period must be >2 cycles.
//  Recording over a clip replaces its length only when that recording ends.
//  play_data_o holds its last value in IDLE.
// STRUCTURE
//  Package audio_pkg: seq_state_e enum (IDLE=0, RECORD=1, PLAY_REQ=2, PLAY_DATA=3),
//  and the DATA_W default as a localparam.
//  Sub-module clip_len_table: NUM_CLIPS x (ADDR_W+1) register file,
//  1 write port, 1 async read port, synchronous clear on reset_i.
// TESTING
//  1. ADDR_W=4, record clip 2 with 5 rec_valid_i, then stop_i
//     -> writes at addr 0x20..0x24; len[2]=5; state IDLE.
//  2. Play clip 2, loop_i=0, 6 ticks
//     -> exactly 5 play_valid_o, data matches the recorded values, each 2 cycles after its tick.
//  3. Play clip 2, loop_i=1, 12 ticks -> sample order 0,1,2,3,4,0,1,...; never enters IDLE.
//  4. Record 16 samples into clip 1 with no stop -> auto-stop after the 16th; len[1]=16;
//     a 17th rec_valid_i causes no write.
//  5. play_i on empty clip 3 -> stays IDLE, no mem_en_o.
//     play_i and record_i in the same cycle -> RECORD.
//  6. reset_i during RECORD of clip 0 (3 samples) -> all outputs 0 next cycle,
//     len[0]=0, a later play of clip 0 is ignored.

Source files
------------

// File: rtl/clip_sequencer_pkg.sv
// Shared definitions for the clip sequencer: FSM state encoding and default sample width.
package audio_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECORD    = 2'd1,
        PLAY_REQ  = 2'd2,
        PLAY_DATA = 2'd3
    } seq_state_e;

endpackage

// File: rtl/clip_sequencer_if.sv
// Single-port sample RAM bus between the sequencer (master) and the block RAM (slave).
interface clip_sequencer_if #(
    parameter int CLIP_W = 2,
    parameter int ADDR_W = 15,
    parameter int DATA_W = audio_pkg::DATA_W_DEFAULT
) ();

    logic                     mem_en;
    logic                     mem_we;
    logic [CLIP_W+ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_rdata;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/clip_sequencer_len_table.sv
// Per-clip recorded-length register file: one write port, one combinational read port.
module clip_len_table #(
    parameter int NUM_CLIPS = 4,
    parameter int LEN_W     = 16,
    localparam int CLIP_W   = $clog2(NUM_CLIPS)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              wr_en,
    input  logic [CLIP_W-1:0] wr_clip,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic [CLIP_W-1:0] rd_clip,
    output logic [LEN_W-1:0]  rd_len
);

    logic [LEN_W-1:0]     len_reg [NUM_CLIPS];
    logic [NUM_CLIPS-1:0] entry_we;

    generate
        for (genvar gi = 0; gi < NUM_CLIPS; gi++) begin : g_entry
            assign entry_we[gi] = wr_en && (wr_clip == CLIP_W'(gi));
        end
    endgenerate

    always_ff @(posedge clock_i) begin
        for (int i = 0; i < NUM_CLIPS; i++) begin
            if (reset_i) begin
                len_reg[i] <= '0;
            end else if (entry_we[i]) begin
                len_reg[i] <= wr_len;
            end
        end
    end

    assign rd_len = len_reg[rd_clip];

endmodule

// File: rtl/clip_sequencer.sv
// Record/playback sequencer for NUM_CLIPS clips sharing one single-port sample RAM,
// with per-clip length tracking, early stop and looped playback.
module clip_sequencer
    import audio_pkg::*;
#(
    parameter int NUM_CLIPS = 4,
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = DATA_W_DEFAULT,
    localparam int CLIP_W   = $clog2(NUM_CLIPS),
    localparam int LEN_W    = ADDR_W + 1
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                play_i,
    input  logic                record_i,
    input  logic                stop_i,
    input  logic                loop_i,
    input  logic [CLIP_W-1:0]   play_clip_i,
    input  logic [CLIP_W-1:0]   record_clip_i,
    input  logic                rec_valid_i,
    input  logic [DATA_W-1:0]   rec_data_i,
    input  logic                sample_tick_i,
    output logic                play_valid_o,
    output logic [DATA_W-1:0]   play_data_o,
    clip_sequencer_if.master    mem,
    output logic [1:0]          state_o,
    output logic [CLIP_W-1:0]   active_clip_o
);

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    seq_state_e          state_reg, state_next;
    logic [CLIP_W-1:0]   clip_reg, clip_next;
    logic [ADDR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [DATA_W-1:0]   play_data_reg, play_data_next;
    logic                play_valid_reg, play_valid_next;

    logic                len_we;
    logic [LEN_W-1:0]    len_wdata;
    logic [CLIP_W-1:0]   len_rclip;
    logic [LEN_W-1:0]    len_rdata;
    logic [LEN_W-1:0]    written_len;

    logic                mem_en;
    logic                mem_we;
    logic [CLIP_W+ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]   mem_wdata;

    // In IDLE the lookup serves the play-command check; otherwise it serves the end-of-clip test.
    assign len_rclip = (state_reg == IDLE) ? play_clip_i : clip_reg;

    clip_len_table #(
        .NUM_CLIPS (NUM_CLIPS),
        .LEN_W     (LEN_W)
    ) u_len_table (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .wr_en   (len_we),
        .wr_clip (clip_reg),
        .wr_len  (len_wdata),
        .rd_clip (len_rclip),
        .rd_len  (len_rdata)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_reg      <= IDLE;
            clip_reg       <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            play_data_reg  <= '0;
            play_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            clip_reg       <= clip_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            play_data_reg  <= play_data_next;
            play_valid_reg <= play_valid_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        clip_next       = clip_reg;
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        play_data_next  = play_data_reg;
        play_valid_next = 1'b0;
        len_we          = 1'b0;
        len_wdata       = '0;
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        written_len     = {1'b0, wr_ptr_reg} + LEN_W'(rec_valid_i);

        case (state_reg)
            IDLE: begin
                if (record_i) begin
                    state_next  = RECORD;
                    clip_next   = record_clip_i;
                    wr_ptr_next = '0;
                end else if (play_i && (len_rdata != '0)) begin
                    state_next  = PLAY_REQ;
                    clip_next   = play_clip_i;
                    rd_ptr_next = '0;
                end
            end
            RECORD: begin
                if (rec_valid_i) begin
                    mem_en      = 1'b1;
                    mem_we      = 1'b1;
                    mem_addr    = {clip_reg, wr_ptr_reg};
                    mem_wdata   = rec_data_i;
                    wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
                end
                // A sample arriving with stop is still counted in the committed length.
                if (stop_i || (rec_valid_i && (wr_ptr_reg == PTR_LAST))) begin
                    len_we     = 1'b1;
                    len_wdata  = written_len;
                    state_next = IDLE;
                end
            end
            PLAY_REQ: begin
                if (stop_i) begin
                    state_next = IDLE;
                end else if (sample_tick_i) begin
                    mem_en     = 1'b1;
                    mem_addr   = {clip_reg, rd_ptr_reg};
                    state_next = PLAY_DATA;
                end
            end
            PLAY_DATA: begin
                play_data_next  = mem.mem_rdata;
                play_valid_next = 1'b1;
                if (stop_i) begin
                    state_next = IDLE;
                end else if (({1'b0, rd_ptr_reg} + LEN_W'(1)) == len_rdata) begin
                    rd_ptr_next = '0;
                    state_next  = loop_i ? PLAY_REQ : IDLE;
                end else begin
                    rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
                    state_next  = PLAY_REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // RAM strobes are combinational; gating with reset keeps a mid-record reset from writing.
    assign mem.mem_en    = mem_en & ~reset_i;
    assign mem.mem_we    = mem_we & ~reset_i;
    assign mem.mem_addr  = reset_i ? '0 : mem_addr;
    assign mem.mem_wdata = reset_i ? '0 : mem_wdata;

    assign play_valid_o  = play_valid_reg;
    assign play_data_o   = play_data_reg;
    assign state_o       = state_reg;
    assign active_clip_o = (state_reg == IDLE) ? '0 : clip_reg;

endmodule

// File: tb/tb_clip_sequencer.sv
// Randomized scoreboard bench for clip_sequencer with a behavioural clip model and RAM model.
module tb_clip_sequencer;
    import audio_pkg::*;

    localparam int NC    = 4;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int CW    = 2;
    localparam int MAW   = CW + AW;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic           we;
        logic [MAW-1:0] addr;
        logic [DW-1:0]  data;
    } mem_exp_t;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } play_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          play = 1'b0, record = 1'b0, stop = 1'b0, loop = 1'b0;
    logic          rec_valid = 1'b0, tick = 1'b0;
    logic [CW-1:0] play_clip = '0, record_clip = '0;
    logic [DW-1:0] rec_data = '0;
    logic          play_valid;
    logic [DW-1:0] play_data;
    logic [1:0]    state;
    logic [CW-1:0] active_clip;

    clip_sequencer_if #(.CLIP_W(CW), .ADDR_W(AW), .DATA_W(DW)) mif ();

    clip_sequencer #(.NUM_CLIPS(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock_i       (clk),
        .reset_i       (reset),
        .play_i        (play),
        .record_i      (record),
        .stop_i        (stop),
        .loop_i        (loop),
        .play_clip_i   (play_clip),
        .record_clip_i (record_clip),
        .rec_valid_i   (rec_valid),
        .rec_data_i    (rec_data),
        .sample_tick_i (tick),
        .play_valid_o  (play_valid),
        .play_data_o   (play_data),
        .mem           (mif),
        .state_o       (state),
        .active_clip_o (active_clip)
    );

    // Block RAM with one cycle of read latency.
    logic [DW-1:0] ram [1 << MAW];
    always @(posedge clk) begin
        if (mif.mem_en) begin
            if (mif.mem_we) ram[mif.mem_addr] <= mif.mem_wdata;
            else            mif.mem_rdata <= ram[mif.mem_addr];
        end
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_exp_t  exp_mem[$];
    play_exp_t exp_play[$];
    mem_exp_t  mon_m;
    play_exp_t mon_p;

    // Reference model: contents and length of each clip as the specification defines them.
    logic [DW-1:0] mdata [NC][DEPTH];
    int            mlen [NC];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (mif.mem_en === 1'b1) begin
            if (exp_mem.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mem_access: got unexpected en we=%0b addr=0x%0h, required no access",
                         mif.mem_we, mif.mem_addr);
            end else begin
                mon_m = exp_mem.pop_front();
                check("mem_we", 32'(mif.mem_we), 32'(mon_m.we));
                check("mem_addr", 32'(mif.mem_addr), 32'(mon_m.addr));
                if (mon_m.we) check("mem_wdata", 32'(mif.mem_wdata), 32'(mon_m.data));
                $display("[TB] cyc %0d mem %s addr=0x%0h data=0x%0h", cyc,
                         mif.mem_we ? "write" : "read", mif.mem_addr, mif.mem_wdata);
            end
        end
        if (play_valid === 1'b1) begin
            if (exp_play.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL play_valid: got unexpected sample 0x%0h, required none", play_data);
            end else begin
                mon_p = exp_play.pop_front();
                check("play_data", 32'(play_data), 32'(mon_p.data));
                check("play_cycle", 32'(cyc), 32'(mon_p.cyc));
                $display("[TB] cyc %0d play sample=0x%0h", cyc, play_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        play = 1'b0; record = 1'b0; stop = 1'b0; rec_valid = 1'b0; tick = 1'b0;
    endtask

    task automatic do_record(input int c, input int n, input bit stop_on_last,
                             input bit send_stop, input bit with_play);
        logic [DW-1:0] buffer [DEPTH];
        int cnt = 0;
        bit on = 1'b1;
        record = 1'b1;
        record_clip = CW'(c);
        if (with_play) begin
            play = 1'b1;
            play_clip = CW'((c + 1) % NC);
        end
        step();
        check("state_after_record_cmd", 32'(state), 32'(RECORD));
        check("active_clip_record", 32'(active_clip), 32'(c));
        for (int i = 0; i < n; i++) begin
            rec_valid = 1'b1;
            rec_data = DW'($urandom);
            if (stop_on_last && i == n - 1) stop = 1'b1;
            if (on) begin
                exp_mem.push_back('{1'b1, MAW'(c * DEPTH + cnt), rec_data});
                buffer[cnt] = rec_data;
                cnt++;
                if (cnt == DEPTH || stop) begin
                    for (int j = 0; j < cnt; j++) mdata[c][j] = buffer[j];
                    mlen[c] = cnt;
                    on = 1'b0;
                end
            end
            step();
            repeat ($urandom_range(0, 2)) step();
        end
        if (send_stop) begin
            stop = 1'b1;
            if (on) begin
                for (int j = 0; j < cnt; j++) mdata[c][j] = buffer[j];
                mlen[c] = cnt;
                on = 1'b0;
            end
            step();
        end
        check("state_after_record", 32'(state), 32'(IDLE));
    endtask

    task automatic do_play(input int c, input bit lp, input int nticks, input bit stop_in_data);
        int idx = 0;
        bit on;
        seq_state_e exp_state;
        loop = lp;
        play = 1'b1;
        play_clip = CW'(c);
        step();
        on = (mlen[c] != 0);
        check("state_after_play_cmd", 32'(state), on ? 32'(PLAY_REQ) : 32'(IDLE));
        if (on) check("active_clip_play", 32'(active_clip), 32'(c));
        for (int t = 0; t < nticks; t++) begin
            repeat ($urandom_range(2, 4)) step();
            tick = 1'b1;
            exp_state = on ? PLAY_DATA : IDLE;
            if (on) begin
                exp_mem.push_back('{1'b0, MAW'(c * DEPTH + idx), '0});
                exp_play.push_back('{mdata[c][idx], cyc + 2});
                idx++;
                if (idx == mlen[c]) begin
                    idx = 0;
                    if (!lp) on = 1'b0;
                end
            end
            step();
            check("state_after_tick", 32'(state), 32'(exp_state));
        end
        if (!stop_in_data) repeat (3) step();
        stop = 1'b1;
        step();
        check("state_after_stop", 32'(state), 32'(IDLE));
        repeat (3) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 32'(state), 32'(IDLE));
        check({tag, "_active_clip"}, 32'(active_clip), 32'd0);
        check({tag, "_play_valid"}, 32'(play_valid), 32'd0);
        check({tag, "_play_data"}, 32'(play_data), 32'd0);
        check({tag, "_mem_en"}, 32'(mif.mem_en), 32'd0);
        check({tag, "_mem_we"}, 32'(mif.mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mif.mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mif.mem_wdata), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NC; i++) mlen[i] = 0;
        repeat (3) step();
        reset = 1'b0;
        check_all_zero("reset");

        // Record five samples into clip 2, then play it once and looped.
        do_record(2, 5, 1'b0, 1'b1, 1'b0);
        do_play(2, 1'b0, 6, 1'b0);
        do_play(2, 1'b1, 12, 1'b0);

        // Fill clip 1 to the end; the extra sample must not be written.
        do_record(1, 17, 1'b0, 1'b0, 1'b0);
        do_play(1, 1'b0, 17, 1'b0);

        // Stop coinciding with the last sample, then stop during the data phase.
        do_record(0, 3 + $urandom_range(0, 4), 1'b1, 1'b0, 1'b0);
        do_play(0, 1'b1, 8, 1'b1);

        // Empty clip is ignored; simultaneous record and play favours record.
        do_play(3, 1'b0, 3, 1'b0);
        do_record(3, 4, 1'b0, 1'b1, 1'b1);
        do_play(3, 1'b0, 5, 1'b0);

        // Reset in the middle of recording clip 0 clears every clip length.
        record = 1'b1;
        record_clip = '0;
        step();
        for (int i = 0; i < 3; i++) begin
            rec_valid = 1'b1;
            rec_data = DW'($urandom);
            exp_mem.push_back('{1'b1, MAW'(i), rec_data});
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero("mid_reset");
        for (int i = 0; i < NC; i++) mlen[i] = 0;
        do_play(0, 1'b0, 3, 1'b0);
        do_play(2, 1'b0, 2, 1'b0);

        for (int r = 0; r < 5; r++) begin
            int c;
            c = $urandom_range(0, NC - 1);
            do_record(c, $urandom_range(1, 20), 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
            do_play(c, 1'($urandom_range(0, 1)), $urandom_range(3, 20), 1'($urandom_range(0, 1)));
        end

        repeat (5) step();
        check("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
        check("play_queue_drained", 32'(exp_play.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
